// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//    Turns the PLL lock flag into an ordered pair of system resets in the
//    clk_1x domain. The asynchronous lock flag is synchronised, and it must
//    stay high for HOLD_CYCLES consecutive cycles. The early reset for
//    peripherals/VDP is then released. STAGE_GAP cycles later, the late
//    reset for CPU/bus masters is released and ready rises. Any loss of lock
//    re-asserts both resets and drops ready.
//
// Ports:
//    clk              in   1            clk_1x from the PLL
//    reset            in   1            asynchronous, active-high (power-on / button)
//    pll_locked       in   1            asynchronous lock flag from the PLL
//    reset_early      out  1            active-high reset for peripherals (registered)
//    reset_late       out  1            active-high reset for CPU (registered)
//    ready            out  1            high only in RUN (registered)
//    lock_loss_count  out  COUNT_WIDTH  saturating count of RUN->WAIT_LOCK exits
//
// Configuration macro:
//    LOCK_LOSS_COUNTER_EN - when defined, lock_loss_count counts each loss of
//    lock taken from RUN and saturates at all-ones. When it is undefined, the
//    port is tied to zero and no counter logic exists.
// ---------------------------------------------------------------------------
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pll_locked,
   output logic                   reset_early,
   output logic                   reset_late,
   output logic                   ready,
   output logic [COUNT_WIDTH-1:0] lock_loss_count
);

   // One counter is shared by HOLD and GAP, so it is sized for the larger window.
   localparam int MAX_WINDOW = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CNT_W      = $clog2(MAX_WINDOW) + 1;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   // Reject configurations the sequencing cannot honour.
   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("reset_sequencer: SYNC_STAGES must be >= 2");
      end
      if (HOLD_CYCLES < 1) begin : g_bad_hold
         $error("reset_sequencer: HOLD_CYCLES must be >= 1");
      end
      if (STAGE_GAP < 1) begin : g_bad_gap
         $error("reset_sequencer: STAGE_GAP must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_GAP       = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_locked_s;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_reset_early;
   logic                   r_reset_late;
   logic                   r_ready;
   logic                   w_reset_early_nxt;
   logic                   w_reset_late_nxt;
   logic                   w_ready_nxt;

   // Synchroniser chain for the asynchronous lock flag. Bit 0 samples the pin.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{1'b0}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign w_locked_s = r_sync[SYNC_STAGES-1];

   // State, shared counter and registered outputs.
   // Reset forces the safe (all-held) values immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_WAIT_LOCK;
         r_cnt         <= CNT_ZERO;
         r_reset_early <= 1'b1;
         r_reset_late  <= 1'b1;
         r_ready       <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_reset_early <= w_reset_early_nxt;
         r_reset_late  <= w_reset_late_nxt;
         r_ready       <= w_ready_nxt;
      end
   end

   // Next-state, counter and next-output decode. Losing lock from any state
   // sends the FSM back to WAIT_LOCK with the counter cleared, so no credit
   // survives into the next attempt.
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_reset_early_nxt = 1'b1;
      w_reset_late_nxt  = 1'b1;
      w_ready_nxt       = 1'b0;

      case (r_state)
         ST_WAIT_LOCK: begin
            if (w_locked_s) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = HOLD_LOAD;
            end else begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = CNT_ZERO;
            end
         end

         ST_HOLD: begin
            if (!w_locked_s) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = CNT_ZERO;
            end else if (r_cnt == CNT_ZERO) begin
               w_state_nxt       = ST_GAP;
               w_cnt_nxt         = GAP_LOAD;
               w_reset_early_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end

         ST_GAP: begin
            if (!w_locked_s) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = CNT_ZERO;
            end else if (r_cnt == CNT_ZERO) begin
               // The early reset is already low, so the late reset can never
               // fall ahead of it.
               w_state_nxt       = ST_RUN;
               w_cnt_nxt         = CNT_ZERO;
               w_reset_early_nxt = 1'b0;
               w_reset_late_nxt  = 1'b0;
               w_ready_nxt       = 1'b1;
            end else begin
               w_cnt_nxt         = r_cnt - CNT_ONE;
               w_reset_early_nxt = 1'b0;
            end
         end

         ST_RUN: begin
            if (!w_locked_s) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = CNT_ZERO;
            end else begin
               w_reset_early_nxt = 1'b0;
               w_reset_late_nxt  = 1'b0;
               w_ready_nxt       = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   assign reset_early = r_reset_early;
   assign reset_late  = r_reset_late;
   assign ready       = r_ready;

`ifdef LOCK_LOSS_COUNTER_EN
   localparam logic [COUNT_WIDTH-1:0] LLC_MAX = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] LLC_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic [COUNT_WIDTH-1:0] r_lock_loss_cnt;
   logic                   w_run_lost_s;

   // Only an exit from RUN counts. Drops during HOLD/GAP are start-up noise.
   assign w_run_lost_s = (r_state == ST_RUN) && !w_locked_s;

   // Saturating lock-loss counter. Only the reset input clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock_loss_cnt <= {COUNT_WIDTH{1'b0}};
      end else if (w_run_lost_s && (r_lock_loss_cnt != LLC_MAX)) begin
         r_lock_loss_cnt <= r_lock_loss_cnt + LLC_ONE;
      end else begin
         r_lock_loss_cnt <= r_lock_loss_cnt;
      end
   end

   assign lock_loss_count = r_lock_loss_cnt;
`else
   assign lock_loss_count = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with SYNC_STAGES=2, HOLD_CYCLES=8 and
// STAGE_GAP=4. Inputs change on the falling clock edge, and outputs are read
// on the following falling edge. A table row therefore shows the outputs
// after one rising edge.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

   localparam int CW = 8;
`ifdef LOCK_LOSS_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          pll_locked;
   logic          reset_early;
   logic          reset_late;
   logic          ready;
   logic [CW-1:0] lock_loss_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          pll;
      logic          e;
      logic          l;
      logic          r;
      logic [CW-1:0] cnt;   // value expected when the counter is enabled
   } vec_t;

   vec_t vecs[$];

   reset_sequencer #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (8),
      .STAGE_GAP   (4),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pll_locked      (pll_locked),
      .reset_early     (reset_early),
      .reset_late      (reset_late),
      .ready           (ready),
      .lock_loss_count (lock_loss_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic e, input logic l,
                           input logic r, input logic [CW-1:0] c);
      chk({tag, " reset_early"}, {31'd0, reset_early}, {31'd0, e});
      chk({tag, " reset_late"},  {31'd0, reset_late},  {31'd0, l});
      chk({tag, " ready"},       {31'd0, ready},       {31'd0, r});
      chk({tag, " count"},       {24'd0, lock_loss_count}, {24'd0, (CNT_EN ? c : 8'd0)});
   endtask

   // Drive pll_locked, let one rising edge pass, and return on the falling edge.
   task automatic cycle(input logic pll);
      pll_locked = pll;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input int n, input logic pll, input logic e, input logic l,
                      input logic r, input logic [CW-1:0] c);
      vec_t v;
      v.pll = pll;
      v.e   = e;
      v.l   = l;
      v.r   = r;
      v.cnt = c;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   initial begin
      int bad_run;
      int bad_idle;

      // Row i covers edge i+1 after the reset is released.
      add(4,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0);  // edges 1-4: no lock
      add(10, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);  // edges 5-14: N=5, HOLD from 7
      add(4,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0);  // edges 15-18: early released
      add(4,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0);  // edges 19-22: RUN
      add(2,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0);  // edges 23-24: M=23, not yet seen
      add(3,  1'b0, 1'b1, 1'b1, 1'b0, 8'd1);  // edges 25-27: back in WAIT_LOCK
      add(4,  1'b1, 1'b1, 1'b1, 1'b0, 8'd1);  // edges 28-31: N=28, HOLD from 30
      add(3,  1'b0, 1'b1, 1'b1, 1'b0, 8'd1);  // edges 32-34: drop during HOLD
      add(10, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);  // edges 35-44: new N=35
      add(4,  1'b1, 1'b0, 1'b1, 1'b0, 8'd1);  // edges 45-48: early released
      add(2,  1'b1, 1'b0, 1'b0, 1'b1, 8'd1);  // edges 49-50: RUN

      // Outputs while reset is held.
      reset      = 1'b1;
      pll_locked = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk_outs("reset_state", 1'b1, 1'b1, 1'b0, 8'd0);
      reset = 1'b0;

      // Main sequence: release, lock loss in RUN, and a lock drop during HOLD.
      foreach (vecs[i]) begin
         cycle(vecs[i].pll);
         chk_outs($sformatf("row%0d", i), vecs[i].e, vecs[i].l, vecs[i].r, vecs[i].cnt);
      end

      // Asynchronous reset in the middle of GAP.
      reset = 1'b1;
      pll_locked = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) cycle(1'b1);    // N=1, so edge 12 is in GAP
      chk_outs("mid_gap", 1'b0, 1'b1, 1'b0, 8'd0);
      #1 reset = 1'b1;
      #1 chk_outs("async_reset", 1'b1, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         cycle(1'b1);
         chk_outs($sformatf("restart_e%0d", k), (k < 11), (k < 15), (k >= 15), 8'd0);
      end

      // Repeated lock losses taken from RUN, to check counter saturation.
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      bad_run = 0;
      for (int it = 1; it <= 300; it++) begin
         repeat (16) cycle(1'b1);
         if (ready !== 1'b1 || reset_late !== 1'b0) bad_run++;
         repeat (4) cycle(1'b0);
         if (it == 1)   chk("count_after_1",   {24'd0, lock_loss_count}, (CNT_EN ? 32'd1   : 32'd0));
         if (it == 254) chk("count_after_254", {24'd0, lock_loss_count}, (CNT_EN ? 32'd254 : 32'd0));
         if (it == 255) chk("count_after_255", {24'd0, lock_loss_count}, (CNT_EN ? 32'd255 : 32'd0));
      end
      chk("count_after_300", {24'd0, lock_loss_count}, (CNT_EN ? 32'd255 : 32'd0));
      chk("run_reached_each_loop", bad_run, 32'd0);

      // Long period with no lock: the resets stay held throughout.
      bad_idle = 0;
      for (int k = 0; k < 10000; k++) begin
         cycle(1'b0);
         if (reset_early !== 1'b1 || reset_late !== 1'b1 || ready !== 1'b0) bad_idle++;
      end
      chk("idle_no_release", bad_idle, 32'd0);

      // Still in WAIT_LOCK: a fresh lock gives the full +10/+14 timing.
      for (int k = 1; k <= 15; k++) begin
         cycle(1'b1);
         if (k == 10 || k == 11 || k == 14 || k == 15)
            chk_outs($sformatf("post_idle_e%0d", k), (k < 11), (k < 15), (k >= 15),
                     8'd255);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
